ahb_mem_sub: RTL and testbench

AHB_MEM_SUB -- requirements
Module: ahb_mem_sub

---
 rtl/ahb_mem_sub.sv | 174 +++++++++++++++++
 tb/tb_ahb_mem_sub.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_sub.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_mem_sub
//  Description : AHB subordinate backed by a byte-strobed word memory. It
//                supports configurable wait states and pipelined back-to-back
//                transfers. Defining the macro AHB_MEM_SUB_ERR_EN enables
//                range, size and alignment error responses. Without it, the
//                word index wraps modulo Depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_mem_sub #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int Depth      = 256,
    parameter int WaitStates = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sel,
    input  logic [AddrWidth-1:0]   addr,
    input  logic                   write,
    input  logic [3:0]             size,
    input  logic [2:0]             burst,
    input  logic [3:0]             prot,
    input  logic                   mastLock,
    input  logic [2:0]             trans,
    input  logic                   ready,
    input  logic [DataWidth-1:0]   wData,
    input  logic [DataWidth/8-1:0] wStrb,
    output logic                   readyOut,
    output logic [1:0]             resp,
    output logic [DataWidth-1:0]   rData
);

    localparam int         c_LANES        = DataWidth / 8;
    localparam int         c_LANE_BITS    = $clog2(c_LANES);
    localparam int         c_IDX_BITS     = $clog2(Depth);
    localparam logic [3:0] c_WAIT_LOAD    = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;
    localparam logic [1:0] c_RESP_OKAY    = 2'd0;
    localparam logic [1:0] c_RESP_ERROR   = 2'd1;
    localparam logic [2:0] c_TRANS_NONSEQ = 3'd2;
    localparam logic [2:0] c_TRANS_SEQ    = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic [AddrWidth-1:0]    addr_q;
    logic                    write_q;
    logic [3:0]              size_q;
    logic [DataWidth-1:0]    mem_q [Depth];

    logic                    w_accept_ok;
    logic                    w_accept;
    logic                    w_err;
    state_t                  w_tgt;
    logic [c_IDX_BITS-1:0]   w_idx;
    logic                    w_wr_en;
    logic                    w_unused;

    // A new address phase is only taken while this subordinate is not stalling.
    assign w_accept_ok = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign w_accept    = w_accept_ok && sel && ready &&
                         ((trans == c_TRANS_NONSEQ) || (trans == c_TRANS_SEQ));

`ifdef AHB_MEM_SUB_ERR_EN
    localparam logic [AddrWidth:0] c_MEM_BYTES = (AddrWidth + 1)'(Depth * c_LANES);
    localparam logic [3:0]         c_MAX_SIZE  = 4'(c_LANE_BITS);
    logic [AddrWidth-1:0] w_align_mask;

    // Classify the transfer being offered: out of range, too wide, or misaligned.
    always_comb begin
        w_align_mask = ~({AddrWidth{1'b1}} << size);
        w_err        = ({1'b0, addr} >= c_MEM_BYTES) ||
                       (size > c_MAX_SIZE) ||
                       ((addr & w_align_mask) != '0);
    end
`else
    assign w_err = 1'b0;
`endif

    // Word index of the transfer in its data phase; upper address bits wrap.
    assign w_idx   = addr_q[c_LANE_BITS +: c_IDX_BITS];
    assign w_wr_en = (state_q == S_DATA) && write_q;

    // Sideband inputs and unused address/size bits are intentionally ignored.
    assign w_unused = ^{burst, prot, mastLock, size_q, addr_q};

    // State, wait counter and address-phase capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (w_accept) begin
                addr_q  <= addr;
                write_q <= write;
                size_q  <= size;
            end
        end
    end

    // Next state, response signalling and read data.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        readyOut = 1'b1;
        resp     = c_RESP_OKAY;
        rData    = '0;
        w_tgt    = w_err ? S_ERR1 : ((WaitStates > 0) ? S_WAIT : S_DATA);

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = w_tgt;
                end
            end
            S_WAIT: begin
                readyOut = 1'b0;
                if (wait_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_DATA: begin
                if (!write_q) begin
                    rData = mem_q[w_idx];
                end
                state_d = w_accept ? w_tgt : S_IDLE;
            end
            S_ERR1: begin
                readyOut = 1'b0;
                resp     = c_RESP_ERROR;
                state_d  = S_ERR2;
            end
            S_ERR2: begin
                resp    = c_RESP_ERROR;
                state_d = w_accept ? w_tgt : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_accept && (w_tgt == S_WAIT)) begin
            wait_d = c_WAIT_LOAD;
        end
    end

    // Memory array is not reset; a reset during a write data phase blocks the commit.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            for (int b = 0; b < c_LANES; b++) begin
                if (wStrb[b]) begin
                    mem_q[w_idx][8*b +: 8] <= wData[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_mem_sub
//  Description : Directed self-checking bench for ahb_mem_sub. Three instances
//                cover zero, two and three wait states. Each instance's ready
//                input is looped back from its own readyOut.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_mem_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Shared ignored sideband inputs.
    logic [2:0] burst_c = 3'd0;
    logic [3:0] prot_c  = 4'd0;
    logic       lock_c  = 1'b0;

    // Instance 0: WaitStates = 0
    logic        rst0, sel0, write0, ro0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  size0, strb0;
    logic [2:0]  trans0;
    logic [1:0]  resp0;

    // Instance 2: WaitStates = 2
    logic        rst2, sel2, write2, ro2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [3:0]  size2, strb2;
    logic [2:0]  trans2;
    logic [1:0]  resp2;

    // Instance 3: WaitStates = 3
    logic        rst3, sel3, write3, ro3;
    logic [31:0] addr3, wdata3, rdata3;
    logic [3:0]  size3, strb3;
    logic [2:0]  trans3;
    logic [1:0]  resp3;

    ahb_mem_sub #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(0)) u_dut0 (
        .clk(clk), .reset(rst0), .sel(sel0), .addr(addr0), .write(write0), .size(size0),
        .burst(burst_c), .prot(prot_c), .mastLock(lock_c), .trans(trans0), .ready(ro0),
        .wData(wdata0), .wStrb(strb0), .readyOut(ro0), .resp(resp0), .rData(rdata0)
    );

    ahb_mem_sub #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(2)) u_dut2 (
        .clk(clk), .reset(rst2), .sel(sel2), .addr(addr2), .write(write2), .size(size2),
        .burst(burst_c), .prot(prot_c), .mastLock(lock_c), .trans(trans2), .ready(ro2),
        .wData(wdata2), .wStrb(strb2), .readyOut(ro2), .resp(resp2), .rData(rdata2)
    );

    ahb_mem_sub #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(3)) u_dut3 (
        .clk(clk), .reset(rst3), .sel(sel3), .addr(addr3), .write(write3), .size(size3),
        .burst(burst_c), .prot(prot_c), .mastLock(lock_c), .trans(trans3), .ready(ro3),
        .wData(wdata3), .wStrb(strb3), .readyOut(ro3), .resp(resp3), .rData(rdata3)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic ap0(input logic w, input logic [31:0] a, input logic [3:0] sz);
        sel0 = 1'b1; trans0 = 3'd2; write0 = w; addr0 = a; size0 = sz;
    endtask

    task automatic idle0();
        sel0 = 1'b0; trans0 = 3'd0;
    endtask

    task automatic wd0(input logic [31:0] d, input logic [3:0] s);
        wdata0 = d; strb0 = s;
    endtask

    // Error-check cases: {addr, size}
    logic [31:0] err_addr [3];
    logic [3:0]  err_size [3];

    // Bounded run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        err_addr[0] = 32'h400; err_size[0] = 4'd2;
        err_addr[1] = 32'h002; err_size[1] = 4'd2;
        err_addr[2] = 32'h000; err_size[2] = 4'd3;

        rst0 = 1'b1; sel0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0; size0 = 4'd2; strb0 = '0; trans0 = '0;
        rst2 = 1'b1; sel2 = 1'b0; write2 = 1'b0; addr2 = '0; wdata2 = '0; size2 = 4'd2; strb2 = '0; trans2 = '0;
        rst3 = 1'b1; sel3 = 1'b0; write3 = 1'b0; addr3 = '0; wdata3 = '0; size3 = 4'd2; strb3 = '0; trans3 = '0;
        repeat (2) @(negedge clk);
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;

        // Reset state
        check_eq("rst_ready", {63'd0, ro0}, 64'd1);
        check_eq("rst_resp", {62'd0, resp0}, 64'd0);
        check_eq("rst_rdata", {32'd0, rdata0}, 64'd0);

        // Write 0xDEADBEEF to 0x10, then read it back-to-back
        ap0(1'b1, 32'h10, 4'd2);
        @(negedge clk);
        check_eq("wr_data_ready", {63'd0, ro0}, 64'd1);
        check_eq("wr_data_rdata", {32'd0, rdata0}, 64'd0);
        wd0(32'hDEADBEEF, 4'hF); ap0(1'b0, 32'h10, 4'd2);
        @(negedge clk);
        check_eq("rd_after_wr", {32'd0, rdata0}, 64'hDEADBEEF);
        check_eq("rd_after_wr_ready", {63'd0, ro0}, 64'd1);
        check_eq("rd_after_wr_resp", {62'd0, resp0}, 64'd0);

        // Byte strobes: 0x11223344 full, then 0xAABBCCDD low half, then read
        ap0(1'b1, 32'h4, 4'd2); wd0(32'h0, 4'h0);
        @(negedge clk);
        wd0(32'h11223344, 4'hF); ap0(1'b1, 32'h4, 4'd2);
        @(negedge clk);
        wd0(32'hAABBCCDD, 4'h3); ap0(1'b0, 32'h4, 4'd2);
        @(negedge clk);
        check_eq("strb_merge", {32'd0, rdata0}, 64'h1122CCDD);

        // Seed word 0 for the error/wrap cases
        ap0(1'b1, 32'h0, 4'd2);
        @(negedge clk);
        wd0(32'h0BADF00D, 4'hF); idle0();
        @(negedge clk);
        check_eq("idle_ready", {63'd0, ro0}, 64'd1);
        check_eq("idle_rdata", {32'd0, rdata0}, 64'd0);

        // No data phase without select, or on BUSY
        sel0 = 1'b0; trans0 = 3'd2; write0 = 1'b0; addr0 = 32'h10;
        @(negedge clk);
        check_eq("nosel_rdata", {32'd0, rdata0}, 64'd0);
        sel0 = 1'b1; trans0 = 3'd1;
        @(negedge clk);
        check_eq("busy_rdata", {32'd0, rdata0}, 64'd0);
        check_eq("busy_ready", {63'd0, ro0}, 64'd1);
        idle0();
        @(negedge clk);

        // Out-of-range, misaligned and oversized reads; each is followed by a read of 0x10
        for (int i = 0; i < 3; i++) begin
            ap0(1'b0, err_addr[i], err_size[i]);
            @(negedge clk);
`ifdef AHB_MEM_SUB_ERR_EN
            check_eq($sformatf("err%0d_ph1_ready", i), {63'd0, ro0}, 64'd0);
            check_eq($sformatf("err%0d_ph1_resp", i), {62'd0, resp0}, 64'd1);
            idle0();
            @(negedge clk);
            check_eq($sformatf("err%0d_ph2_ready", i), {63'd0, ro0}, 64'd1);
            check_eq($sformatf("err%0d_ph2_resp", i), {62'd0, resp0}, 64'd1);
            check_eq($sformatf("err%0d_ph2_rdata", i), {32'd0, rdata0}, 64'd0);
`else
            check_eq($sformatf("wrap%0d_ready", i), {63'd0, ro0}, 64'd1);
            check_eq($sformatf("wrap%0d_resp", i), {62'd0, resp0}, 64'd0);
            check_eq($sformatf("wrap%0d_rdata", i), {32'd0, rdata0}, 64'h0BADF00D);
`endif
            ap0(1'b0, 32'h10, 4'd2);
            @(negedge clk);
            check_eq($sformatf("post%0d_rdata", i), {32'd0, rdata0}, 64'hDEADBEEF);
            check_eq($sformatf("post%0d_resp", i), {62'd0, resp0}, 64'd0);
            idle0();
            @(negedge clk);
        end

        // Two wait states: write 0x55AA55AA to 0x0, then read it back
        sel2 = 1'b1; trans2 = 3'd2; write2 = 1'b1; addr2 = 32'h0;
        @(negedge clk);
        check_eq("ws2_wr_w1", {63'd0, ro2}, 64'd0);
        trans2 = 3'd0; wdata2 = 32'h55AA55AA; strb2 = 4'hF;
        @(negedge clk);
        check_eq("ws2_wr_w2", {63'd0, ro2}, 64'd0);
        @(negedge clk);
        check_eq("ws2_wr_data_ready", {63'd0, ro2}, 64'd1);
        trans2 = 3'd2; write2 = 1'b0; addr2 = 32'h0;
        @(negedge clk);
        check_eq("ws2_rd_w1", {63'd0, ro2}, 64'd0);
        check_eq("ws2_rd_w1_rdata", {32'd0, rdata2}, 64'd0);
        trans2 = 3'd0;
        @(negedge clk);
        check_eq("ws2_rd_w2", {63'd0, ro2}, 64'd0);
        @(negedge clk);
        check_eq("ws2_rd_ready", {63'd0, ro2}, 64'd1);
        check_eq("ws2_rd_resp", {62'd0, resp2}, 64'd0);
        check_eq("ws2_rd_rdata", {32'd0, rdata2}, 64'h55AA55AA);
        sel2 = 1'b0;
        @(negedge clk);
        check_eq("ws2_idle_ready", {63'd0, ro2}, 64'd1);

        // Three wait states: commit 0x12345678 at 0x8
        sel3 = 1'b1; trans3 = 3'd2; write3 = 1'b1; addr3 = 32'h8;
        @(negedge clk);
        trans3 = 3'd0; wdata3 = 32'h12345678; strb3 = 4'hF;
        repeat (3) @(negedge clk);
        check_eq("ws3_wr1_ready", {63'd0, ro3}, 64'd1);
        // Overwrite attempt interrupted by reset in its second wait cycle
        trans3 = 3'd2; write3 = 1'b1; addr3 = 32'h8;
        @(negedge clk);
        check_eq("ws3_wr2_w1", {63'd0, ro3}, 64'd0);
        trans3 = 3'd0; wdata3 = 32'hFFFFFFFF;
        @(negedge clk);
        check_eq("ws3_wr2_w2", {63'd0, ro3}, 64'd0);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        check_eq("ws3_rst_ready", {63'd0, ro3}, 64'd1);
        check_eq("ws3_rst_resp", {62'd0, resp3}, 64'd0);
        check_eq("ws3_rst_rdata", {32'd0, rdata3}, 64'd0);
        // Read back: three wait cycles, then original data
        trans3 = 3'd2; write3 = 1'b0; addr3 = 32'h8;
        @(negedge clk);
        trans3 = 3'd0;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("ws3_rd_w%0d", k + 1), {63'd0, ro3}, 64'd0);
            @(negedge clk);
        end
        check_eq("ws3_rd_ready", {63'd0, ro3}, 64'd1);
        check_eq("ws3_rd_rdata", {32'd0, rdata3}, 64'h12345678);
        sel3 = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
